// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: sequences FETCH/DECODE/execute/writeback one instruction at a time.
// Latency: lw 5, sw 4, R-type 4, beq 3, j 3 (addi 4 with MC_CTRL_ADDI_EN) cycles with mem_ready held high.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; a stall counter pulses mem_timeout once, no abort.
// Optional feature: define MC_CTRL_ADDI_EN to build the ADDI/ADDIWB states for opcode 001000.
module mc_ctrl_fsm #(
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
`ifdef MC_CTRL_ADDI_EN
        S_JUMP   = 4'd9,
        S_ADDI   = 4'd10,
        S_ADDIWB = 4'd11
`else
        S_JUMP   = 4'd9
`endif
    } state_t;

    localparam logic [7:0] L_TO    = 8'(FETCH_TIMEOUT);
    localparam logic       L_TO_EN = (FETCH_TIMEOUT != 0);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_stall_cnt;
    logic       w_wait;

    logic       w_mem_read, w_mem_write, w_ir_write, w_reg_write;
    logic       w_pc_write, w_branch, w_instr_done, w_illegal;
    logic       w_timeout;

    // State register; reset aborts any instruction straight back to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // A wait cycle is a memory state without mem_ready; anything else clears the count.
    assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR)) && !mem_ready;

    // Stall counter saturates at the timeout so the pulse fires only once per stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_stall_cnt <= 8'd0;
        else if (!w_wait)            r_stall_cnt <= 8'd0;
        else if (r_stall_cnt != L_TO) r_stall_cnt <= r_stall_cnt + 8'd1;
    end

    // Pulse on the wait cycle that brings the count up to the timeout.
    assign w_timeout = L_TO_EN && w_wait && (r_stall_cnt != L_TO) && ((r_stall_cnt + 8'd1) == L_TO);

    // Next-state and state-decoded outputs; defaults first, mem_ready/zero only where they matter.
    always_comb begin
        w_next       = r_state;
        alu_op       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b = 2'b11;
                case (opcode)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = S_RTYPE;
                    6'b000100:            w_next = S_BEQ;
                    6'b000010:            w_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    6'b001000:            w_next = S_ADDI;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg   = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_RTYPE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst      = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b01;
                pc_src       = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Enables and pulses are forced low while reset is held so nothing leaks out mid-abort.
    assign mem_read    = w_mem_read   & ~rst;
    assign mem_write   = w_mem_write  & ~rst;
    assign ir_write    = w_ir_write   & ~rst;
    assign reg_write   = w_reg_write  & ~rst;
    assign pc_en       = (w_pc_write | (w_branch & zero)) & ~rst;
    assign instr_done  = w_instr_done & ~rst;
    assign illegal_op  = w_illegal    & ~rst;
    assign mem_timeout = w_timeout    & ~rst;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm (FETCH_TIMEOUT=4): per-cycle stimulus and expected outputs queued, then drained.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Honors MC_CTRL_ADDI_EN when choosing addi expectations.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
        logic       reg_write, pc_en, instr_done, illegal_op, mem_timeout;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       mr;
        logic       z;
        outs_t      exp;
        string      name;
    } ent_t;

    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4, S_MEMWB = 5,
                   S_MEMWR = 6, S_RTYPE = 7, S_ALUWB = 8, S_BEQ = 9, S_JUMP = 10, S_ADDI = 11, S_ADDIWB = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    outs_t      o;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    mc_ctrl_fsm #(.FETCH_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(o.alu_op), .alu_src_a(o.alu_src_a), .alu_src_b(o.alu_src_b), .pc_src(o.pc_src),
        .iord(o.iord), .mem_read(o.mem_read), .mem_write(o.mem_write), .ir_write(o.ir_write),
        .reg_dst(o.reg_dst), .mem_to_reg(o.mem_to_reg), .reg_write(o.reg_write), .pc_en(o.pc_en),
        .instr_done(o.instr_done), .illegal_op(o.illegal_op), .mem_timeout(o.mem_timeout)
    );

    always #5 clk = ~clk;

    // Expected outputs per state, written from the state table.
    function automatic outs_t spec_out(int st, bit mr, bit z, bit ill, bit to);
        outs_t e = '0;
        case (st)
            S_RST:    e.alu_src_b = 2'b01;
            S_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
            S_DECODE: begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
            S_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MEMRD:  begin e.iord = 1; e.mem_read = 1; end
            S_MEMWB:  begin e.mem_to_reg = 1; e.reg_write = 1; e.instr_done = 1; end
            S_MEMWR:  begin e.iord = 1; e.mem_write = 1; e.instr_done = mr; end
            S_RTYPE:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            S_ALUWB:  begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; end
            S_BEQ:    begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; e.instr_done = 1; end
            S_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1; e.instr_done = 1; end
            S_ADDI:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_ADDIWB: begin e.reg_write = 1; e.instr_done = 1; end
            default:  e = '0;
        endcase
        e.mem_timeout = to;
        return e;
    endfunction

    task automatic push(input int st, input logic [5:0] op, input bit mr, input bit z,
                        input bit ill, input bit to, input string name);
        ent_t e;
        e.rst = 1'b0; e.op = op; e.mr = mr; e.z = z;
        e.exp = spec_out(st, mr, z, ill, to);
        e.name = name;
        q.push_back(e);
    endtask

    // Apply each queued cycle's inputs, compare on the falling edge, advance one cycle.
    task automatic drain();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            rst = e.rst; opcode = e.op; mem_ready = e.mr; zero = e.z;
            @(negedge clk);
            checks++;
            if (o !== e.exp) begin
                errors++;
                $display("FAIL %s got %h exp %h", e.name, o, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        ent_t e;
        e.rst = 1'b1; e.op = 6'b0; e.mr = 1'b1; e.z = 1'b1;
        e.exp = spec_out(S_RST, 0, 0, 0, 0); e.name = "reset_hold";
        q.push_back(e);
        q.push_back(e);
        push(S_FETCH, 6'b0, 0, 0, 0, 0, "reset_release_fetch");
        drain();
    endtask

    task automatic test_lw();
        push(S_FETCH,  6'b100011, 1, 0, 0, 0, "lw_fetch");
        push(S_DECODE, 6'b100011, 1, 0, 0, 0, "lw_decode");
        push(S_MEMADR, 6'b100011, 1, 0, 0, 0, "lw_memadr");
        push(S_MEMRD,  6'b100011, 1, 0, 0, 0, "lw_memrd");
        push(S_MEMWB,  6'b100011, 1, 0, 0, 0, "lw_memwb");
        drain();
    endtask

    task automatic test_sw();
        push(S_FETCH,  6'b101011, 1, 0, 0, 0, "sw_fetch");
        push(S_DECODE, 6'b101011, 1, 0, 0, 0, "sw_decode");
        push(S_MEMADR, 6'b101011, 1, 0, 0, 0, "sw_memadr");
        push(S_MEMWR,  6'b101011, 1, 0, 0, 0, "sw_memwr");
        drain();
    endtask

    task automatic test_beq();
        for (int k = 1; k >= 0; k--) begin
            push(S_FETCH,  6'b000100, 1, k[0], 0, 0, "beq_fetch");
            push(S_DECODE, 6'b000100, 1, k[0], 0, 0, "beq_decode");
            push(S_BEQ,    6'b000100, 1, k[0], 0, 0, k[0] ? "beq_taken" : "beq_not_taken");
        end
        drain();
    endtask

    task automatic test_jump();
        push(S_FETCH,  6'b000010, 1, 0, 0, 0, "j_fetch");
        push(S_DECODE, 6'b000010, 1, 0, 0, 0, "j_decode");
        push(S_JUMP,   6'b000010, 1, 0, 0, 0, "j_jump");
        drain();
    endtask

    task automatic test_rtype_stall();
        for (int k = 1; k <= 10; k++)
            push(S_FETCH, 6'b000000, 0, 0, 0, (k == 4), "rtype_fetch_stall");
        push(S_FETCH,  6'b000000, 1, 0, 0, 0, "rtype_fetch_ready");
        push(S_DECODE, 6'b000000, 1, 0, 0, 0, "rtype_decode");
        push(S_RTYPE,  6'b000000, 1, 0, 0, 0, "rtype_exec");
        push(S_ALUWB,  6'b000000, 1, 0, 0, 0, "rtype_aluwb");
        drain();
    endtask

    task automatic test_timeout();
        push(S_FETCH,  6'b100011, 1, 0, 0, 0, "to_fetch");
        push(S_DECODE, 6'b100011, 1, 0, 0, 0, "to_decode");
        push(S_MEMADR, 6'b100011, 1, 0, 0, 0, "to_memadr");
        for (int k = 1; k <= 20; k++)
            push(S_MEMRD, 6'b100011, 0, 0, 0, (k == 4), "to_memrd_stall");
        push(S_MEMRD,  6'b100011, 1, 0, 0, 0, "to_memrd_ready");
        push(S_MEMWB,  6'b100011, 1, 0, 0, 0, "to_memwb");
        drain();
    endtask

    task automatic test_addi();
        push(S_FETCH, 6'b001000, 1, 0, 0, 0, "addi_fetch");
`ifdef MC_CTRL_ADDI_EN
        push(S_DECODE, 6'b001000, 1, 0, 0, 0, "addi_decode");
        push(S_ADDI,   6'b001000, 1, 0, 0, 0, "addi_exec");
        push(S_ADDIWB, 6'b001000, 1, 0, 0, 0, "addi_wb");
`else
        push(S_DECODE, 6'b001000, 1, 0, 1, 0, "addi_illegal");
`endif
        push(S_FETCH, 6'b111111, 1, 0, 0, 0, "illegal_fetch");
        push(S_DECODE, 6'b111111, 1, 0, 1, 0, "illegal_decode");
        drain();
    endtask

    task automatic test_reset_memwr();
        push(S_FETCH,  6'b101011, 1, 0, 0, 0, "rstwr_fetch");
        push(S_DECODE, 6'b101011, 1, 0, 0, 0, "rstwr_decode");
        push(S_MEMADR, 6'b101011, 1, 0, 0, 0, "rstwr_memadr");
        push(S_MEMWR,  6'b101011, 0, 0, 0, 0, "rstwr_memwr_stall");
        drain();
        rst = 1'b1;
        #1;
        checks++;
        if (o !== spec_out(S_RST, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rstwr_async_drop got %h exp %h", o, spec_out(S_RST, 0, 0, 0, 0));
        end
        @(posedge clk); #1;
        push(S_FETCH, 6'b0, 0, 0, 0, 0, "rstwr_after_release");
        drain();
    endtask

    task automatic test_back_to_back();
        test_sw();
        test_lw();
        test_jump();
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_jump();
        test_rtype_stall();
        test_timeout();
        test_addi();
        test_reset_memwr();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main controller; sequences the shared ALU, register file, memory port, IR and PC one instruction at a time.
- Decodes opcode into a state sequence and drives the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 subtract, 10 funct-decoded).
- Stalls on a memory ready handshake; flags unsupported opcodes.

Parameters:
- FETCH_TIMEOUT, 255, max cycles waiting in a memory state before mem_timeout pulses; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26], read from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  2  00 add, 01 sub, 10 funct
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-imm, 11 sign-imm<<2
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  0 PC addresses memory, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- pc_en  out  1  PC load = pc_write | (branch & zero)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when the stall count reaches FETCH_TIMEOUT

Behaviour:
- State register is 4 bits. Outputs are decoded from the state, plus mem_ready and zero where stated.
- Reset: state is FETCH. While rst is high, every enable (pc_en, ir_write, reg_write, mem_read, mem_write) and every pulse output is 0. All mux selects are 0 except alu_src_b=01.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en equal mem_ready. Holds until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPE
  - 000100 -> BEQ
  - 001000 -> ADDI (only when the optional feature is enabled)
  - 000010 -> JUMP
  - any other opcode -> FETCH with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWR: iord=1, mem_write=1. Holds until mem_ready. On the mem_ready cycle instr_done=1, then goes to FETCH.
- RTYPE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 (so pc_en=zero), instr_done=1. Goes to FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Goes to FETCH.
- Stall counter:
  - 8 bits; clears on entry to FETCH, MEMRD or MEMWR and whenever mem_ready=1; increments each waiting cycle.
  - When it equals FETCH_TIMEOUT (nonzero), mem_timeout pulses once and the counter saturates. The FSM keeps waiting; no abort.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- rst asserted mid-instruction aborts immediately to FETCH. No partial write is issued after rst rises.
- Cycle counts with mem_ready=1 every cycle: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4.

Optional Feature:
- Macro: MC_CTRL_ADDI_EN.
- Defined: opcode 001000 goes DECODE -> ADDI -> ADDIWB.
  - ADDI: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1.
- Undefined: 001000 is illegal (illegal_op pulse in DECODE, return to FETCH), and the ADDI states are not built.

Test Plan:
- rst=1 mid-MEMWR with mem_write=1 -> mem_write drops asynchronously; after release the state is FETCH with mem_read=1 and no reg_write or pc_en.
- lw (100011), mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done pulses once.
- beq (000100) with zero=1, then zero=0 -> pc_en=1 with pc_src=01 in cycle 3 for the first; pc_en=0 for the second. alu_op=01 in both.
- R-type (000000) with mem_ready held low 10 cycles in FETCH -> ir_write and pc_en stay 0 for 10 cycles; then 1 for one cycle; then alu_op=10 in RTYPE and reg_dst=1 in ALUWB.
- FETCH_TIMEOUT=4, mem_ready low 20 cycles in MEMRD -> exactly one mem_timeout pulse on the 4th wait cycle; the FSM stays in MEMRD.
- opcode 001000 with and without MC_CTRL_ADDI_EN -> enabled: 4-cycle addi with reg_write in ADDIWB. Disabled: illegal_op=1 in DECODE, next state FETCH, no reg_write.
